// File: rtl/mips_alu_unit.sv
// Execute-stage arithmetic block for the single-cycle MIPS core: immediate sign
// extension, ALU-control decode, operand-B mux, ALU, plus a registered trace copy.
module mips_alu_unit #(
    parameter int BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [BITS-1:0] a,
    input  logic signed [BITS-1:0] b,
    input  logic        [15:0]     imm16,
    input  logic                   alu_src,
    input  logic        [1:0]      alu_op,
    input  logic        [5:0]      funct,
    output logic        [BITS-1:0] imm32,
    output logic        [2:0]      alu_ctrl,
    output logic        [BITS-1:0] alu_out,
    output logic                   zero,
    output logic        [BITS-1:0] result_q,
    output logic                   zero_q
);

    localparam logic [1:0] OP_MEM   = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic signed [BITS-1:0] f_sext16(input logic [15:0] v);
        return BITS'($signed(v));
    endfunction

    // ALUOp 11 is not issued by the main controller today; it falls back to add.
    function automatic logic [2:0] f_alu_ctrl(input logic [1:0] op, input logic [5:0] fn);
        logic [2:0] c;
        c = ALU_ADD;
        case (op)
            OP_MEM:    c = ALU_ADD;
            OP_BRANCH: c = ALU_SUB;
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  c = ALU_ADD;
                    FN_SUB:  c = ALU_SUB;
                    FN_AND:  c = ALU_AND;
                    FN_OR:   c = ALU_OR;
                    FN_SLT:  c = ALU_SLT;
                    default: c = ALU_ADD;
                endcase
            end
            default:   c = ALU_ADD;
        endcase
        return c;
    endfunction

    // slt uses a direct signed compare, so it stays correct when a - opb overflows.
    function automatic logic [BITS-1:0] f_alu(input logic [2:0] ctrl,
                                              input logic signed [BITS-1:0] x,
                                              input logic signed [BITS-1:0] y);
        logic [BITS-1:0] r;
        r = '0;
        case (ctrl)
            ALU_AND: r = x & y;
            ALU_OR:  r = x | y;
            ALU_ADD: r = x + y;
            ALU_SUB: r = x - y;
            ALU_SLT: r = {{(BITS-1){1'b0}}, (x < y)};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic signed [BITS-1:0] w_imm32_p0;
    logic signed [BITS-1:0] w_opb_p0;
    logic        [2:0]      w_ctrl_p0;
    logic        [BITS-1:0] w_result_p0;
    logic                   w_zero_p0;
    logic        [BITS-1:0] r_result_p1;
    logic                   r_zero_p1;

    // Stage p0: combinational single-cycle path
    assign w_imm32_p0  = f_sext16(imm16);
    assign w_opb_p0    = alu_src ? w_imm32_p0 : b;
    assign w_ctrl_p0   = f_alu_ctrl(alu_op, funct);
    assign w_result_p0 = f_alu(w_ctrl_p0, a, w_opb_p0);
    assign w_zero_p0   = ~|w_result_p0;

    // Stage p1: registered trace copy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_p1 <= '0;
            r_zero_p1   <= 1'b0;
        end else begin
            r_result_p1 <= w_result_p0;
            r_zero_p1   <= w_zero_p0;
        end
    end

    assign imm32    = w_imm32_p0;
    assign alu_ctrl = w_ctrl_p0;
    assign alu_out  = w_result_p0;
    assign zero     = w_zero_p0;
    assign result_q = r_result_p1;
    assign zero_q   = r_zero_p1;

endmodule

// File: tb/tb_mips_alu_unit.sv
// Randomized bench for mips_alu_unit against an operation-level reference model.
module tb_mips_alu_unit;

    logic               clk;
    logic               rst;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic        [15:0] imm16;
    logic               alu_src;
    logic        [1:0]  alu_op;
    logic        [5:0]  funct;
    logic        [31:0] imm32;
    logic        [2:0]  alu_ctrl;
    logic        [31:0] alu_out;
    logic               zero;
    logic        [31:0] result_q;
    logic               zero_q;

    int n_checks = 0;
    int n_errors = 0;
    int vec_no   = 0;

    logic [31:0] exp_imm;
    logic [2:0]  exp_ctrl;
    logic [31:0] exp_out;

    mips_alu_unit #(.BITS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .imm16    (imm16),
        .alu_src  (alu_src),
        .alu_op   (alu_op),
        .funct    (funct),
        .imm32    (imm32),
        .alu_ctrl (alu_ctrl),
        .alu_out  (alu_out),
        .zero     (zero),
        .result_q (result_q),
        .zero_q   (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s vec=%0d got=%h expected=%h", tag, vec_no, got, exp);
        end
    endtask

    // Reference: name the instruction's operation, then evaluate it with integer arithmetic.
    function automatic void ref_model(input logic [31:0] ma, input logic [31:0] mb,
                                      input logic [15:0] mi, input logic ms,
                                      input logic [1:0] mo, input logic [5:0] mf,
                                      output logic [31:0] ei, output logic [2:0] ec,
                                      output logic [31:0] eo);
        string  opname;
        longint sa, sb;
        int     si;
        logic [31:0] opb;
        si = int'(shortint'(mi));
        ei = 32'(si);
        opname = "add";
        if (mo == 2'b01) opname = "sub";
        else if (mo == 2'b10) begin
            if (mf == 6'h22) opname = "sub";
            else if (mf == 6'h24) opname = "and";
            else if (mf == 6'h25) opname = "or";
            else if (mf == 6'h2A) opname = "slt";
        end
        opb = ms ? ei : mb;
        sa  = longint'(int'(ma));
        sb  = longint'(int'(opb));
        if (opname == "add")      begin ec = 3'd2; eo = 32'(sa + sb); end
        else if (opname == "sub") begin ec = 3'd6; eo = 32'(sa - sb); end
        else if (opname == "and") begin ec = 3'd0; eo = ma & opb; end
        else if (opname == "or")  begin ec = 3'd1; eo = ma | opb; end
        else                      begin ec = 3'd7; eo = (sa < sb) ? 32'd1 : 32'd0; end
    endfunction

    task automatic apply(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [15:0] ti, input logic ts,
                         input logic [1:0] to, input logic [5:0] tf);
        @(negedge clk);
        vec_no++;
        a = ta; b = tb_v; imm16 = ti; alu_src = ts; alu_op = to; funct = tf;
        #1;
        ref_model(ta, tb_v, ti, ts, to, tf, exp_imm, exp_ctrl, exp_out);
        check("imm32", imm32, exp_imm);
        check("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, exp_ctrl});
        check("alu_out", alu_out, exp_out);
        check("zero", {31'd0, zero}, {31'd0, exp_out == 32'd0});
        @(posedge clk);
        #1;
        if (rst) begin
            check("result_q_rst", result_q, 32'd0);
            check("zero_q_rst", {31'd0, zero_q}, 32'd0);
        end else begin
            check("result_q", result_q, exp_out);
            check("zero_q", {31'd0, zero_q}, {31'd0, exp_out == 32'd0});
        end
    endtask

    function automatic logic [31:0] pick_word();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] pick_funct();
        case ($urandom_range(0, 7))
            0: return 6'h20;
            1: return 6'h22;
            2: return 6'h24;
            3: return 6'h25;
            4: return 6'h2A;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; a = '0; b = '0; imm16 = '0; alu_src = 1'b0; alu_op = 2'b00; funct = '0;
        @(posedge clk); #1;
        check("reset_result_q", result_q, 32'd0);
        check("reset_zero_q", {31'd0, zero_q}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-computed constants alongside the model
        apply(32'd7, 32'd5, 16'h0000, 1'b0, 2'b10, 6'b100000);
        check("t1_out", alu_out, 32'd12);
        check("t1_q", result_q, 32'd12);
        apply(32'h1234, 32'h1234, 16'h0000, 1'b0, 2'b01, 6'h00);
        check("t2_zero", {31'd0, zero}, 32'd1);
        apply(32'd3, 32'd4, 16'h0000, 1'b0, 2'b01, 6'h00);
        check("t2_neg", alu_out, 32'hFFFF_FFFF);
        apply(32'd100, 32'd0, 16'hFFFC, 1'b1, 2'b00, 6'h00);
        check("t3_imm", imm32, 32'hFFFF_FFFC);
        check("t3_out", alu_out, 32'd96);
        apply(32'd0, 32'd0, 16'h7FFF, 1'b1, 2'b00, 6'h00);
        check("t3_imm_pos", imm32, 32'h0000_7FFF);
        apply(32'h8000_0000, 32'd1, 16'h0000, 1'b0, 2'b10, 6'b101010);
        check("t4_slt_a", alu_out, 32'd1);
        apply(32'd1, 32'h8000_0000, 16'h0000, 1'b0, 2'b10, 6'b101010);
        check("t4_slt_b", alu_out, 32'd0);
        apply(32'hFFFF_FFFF, 32'd0, 16'h0000, 1'b0, 2'b10, 6'b101010);
        check("t4_slt_c", alu_out, 32'd1);
        apply(32'hF0F0, 32'h0FF0, 16'h0000, 1'b0, 2'b10, 6'b100100);
        check("t5_and", alu_out, 32'h00F0);
        apply(32'hF0F0, 32'h0FF0, 16'h0000, 1'b0, 2'b10, 6'b100101);
        check("t5_or", alu_out, 32'hFFF0);
        apply(32'hFFFF_FFFF, 32'd1, 16'h0000, 1'b0, 2'b10, 6'b100000);
        check("t5_wrap", alu_out, 32'd0);
        check("t5_zero_q", {31'd0, zero_q}, 32'd1);
        apply(32'd9, 32'd6, 16'h0000, 1'b0, 2'b10, 6'b000000);
        check("t6_fallback", {29'd0, alu_ctrl}, 32'd2);
        apply(32'd1, 32'd2, 16'h0003, 1'b1, 2'b11, 6'h22);
        check("op11_add", alu_out, 32'd4);

        // Mid-stream reset for two edges with a nonzero result, then release
        rst = 1'b1;
        apply(32'd20, 32'd22, 16'h0000, 1'b0, 2'b00, 6'h00);
        apply(32'd20, 32'd22, 16'h0000, 1'b0, 2'b00, 6'h00);
        check("rst_comb_live", alu_out, 32'd42);
        rst = 1'b0;
        apply(32'd20, 32'd22, 16'h0000, 1'b0, 2'b00, 6'h00);
        check("rst_release_q", result_q, 32'd42);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            apply(pick_word(), pick_word(), 16'($urandom), 1'($urandom),
                  2'($urandom), pick_funct());
        end
        rst = 1'b0;
        apply(32'd5, 32'd5, 16'h0000, 1'b0, 2'b01, 6'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
